// File: rtl/nv_ram_rwsthp_param.sv
// nv_ram_rwsthp_param: parametrised two-port RAM wrapper.
// It has one write port, a registered read address, a gated output register
// and a bypass mux. It also provides a post-reset init sweep, optional
// write-to-read forwarding, output-valid tracking and a sticky
// out-of-range address flag.
module nv_ram_rwsthp_param #(
    parameter int               DEPTH    = 60,
    parameter int               WIDTH    = 21,
    parameter int               AW       = 6,
    parameter bit               INIT_EN  = 1'b1,
    parameter logic [WIDTH-1:0] INIT_VAL = '0,
    parameter bit               FWD_EN   = 1'b0,
    parameter bit               FORCE_CONTENTION_ASSERTION_RESET_ACTIVE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    ra,
    input  logic             re,
    input  logic             ore,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    input  logic [AW-1:0]    wa,
    input  logic             we,
    input  logic [WIDTH-1:0] di,
    input  logic             byp_sel,
    input  logic [WIDTH-1:0] dbyp,
    input  logic [31:0]      pwrbus_ram_pd,
    output logic             init_busy,
    output logic             addr_err
);

    localparam logic [0:0]    ST_IDLE   = 1'b0;
    localparam logic [0:0]    ST_INIT   = 1'b1;
    localparam logic [0:0]    ST_RESET  = INIT_EN ? ST_INIT : ST_IDLE;
    localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    // The power-down bus and the contention parameter exist only so this
    // block can drop in for the old fixed-size RAMs.
    localparam bit unused_force_contention = FORCE_CONTENTION_ASSERTION_RESET_ACTIVE;
    logic unused_pwrbus;
    assign unused_pwrbus = ^pwrbus_ram_pd;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [0:0]       state_q,    state_d;
    logic [AW-1:0]    init_ptr_q, init_ptr_d;
    logic [AW-1:0]    ra_lat_q,   ra_lat_d;
    logic             rd_pend_q,  rd_pend_d;
    logic [WIDTH-1:0] dout_q,     dout_d;
    logic             dout_vld_q, dout_vld_d;
    logic             addr_err_q, addr_err_d;

    logic             wr_ok, rd_ok, fwd_hit;
    logic [WIDTH-1:0] ram_q;
    logic             mem_we;
    logic [AW-1:0]    mem_wa;
    logic [WIDTH-1:0] mem_wd;

    assign init_busy = (state_q == ST_INIT);
    assign wr_ok     = ({1'b0, wa} < DEPTH_W);
    assign rd_ok     = ({1'b0, ra_lat_q} < DEPTH_W);
    assign ram_q     = rd_ok ? mem[ra_lat_q] : '0;
    assign fwd_hit   = FWD_EN && we && (wa == ra_lat_q);
    assign dout      = dout_q;
    assign dout_vld  = dout_vld_q;
    assign addr_err  = addr_err_q;

    // Init sweep: step the pointer through every word, then go idle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so that no path leaves it unassigned and infers a latch.
        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        if (state_q == ST_INIT) begin
            init_ptr_d = init_ptr_q + AW'(1);
            if (init_ptr_q == LAST_ADDR) begin
                state_d = ST_IDLE;
            end
        end
    end

    // Memory write source: the sweep owns the array while busy; otherwise
    // only in-range user writes reach it.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = init_ptr_q;
        mem_wd = INIT_VAL;
        if (init_busy) begin
            mem_we = 1'b1;
        end else if (we && wr_ok) begin
            mem_we = 1'b1;
            mem_wa = wa;
            mem_wd = di;
        end
    end

    // Read address latch, output capture, valid tracking and range flag.
    always_comb begin
        ra_lat_d   = ra_lat_q;
        rd_pend_d  = rd_pend_q;
        dout_d     = dout_q;
        dout_vld_d = dout_vld_q;
        addr_err_d = addr_err_q;
        if (!init_busy) begin
            if (re) begin
                ra_lat_d = ra;
            end
            rd_pend_d = re | (rd_pend_q & ~ore);
            if (we && !wr_ok) begin
                addr_err_d = 1'b1;
            end
            if (ore) begin
                if (byp_sel) begin
                    dout_d = dbyp;
                end else if (fwd_hit) begin
                    dout_d = di;
                end else begin
                    dout_d = ram_q;
                end
                dout_vld_d = rd_pend_q | byp_sel;
                if (!rd_ok) begin
                    addr_err_d = 1'b1;
                end
            end
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q    <= ST_RESET;
            init_ptr_q <= '0;
            ra_lat_q   <= '0;
            rd_pend_q  <= 1'b0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
            ra_lat_q   <= ra_lat_d;
            rd_pend_q  <= rd_pend_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset term so it maps onto RAM; only the sweep initialises it.
        if (!rst && mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

endmodule
